// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - player/projectile collision detect with hit, invulnerability, lives and game-over sequencing
module collision_ctrl #(
    parameter int HIT_W      = 40,
    parameter int HIT_CYCLES = 1000000,
    parameter int INV_CYCLES = 50000000,
    parameter int LIVES_INIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] PLANE_x,
    input  logic [11:0] PLANE_y,
    input  logic [11:0] ENEMYPRO_x0,
    input  logic [11:0] ENEMYPRO_y0,
    input  logic [11:0] ENEMYPRO_x1,
    input  logic [11:0] ENEMYPRO_y1,
    input  logic [11:0] ENEMYPRO_x2,
    input  logic [11:0] ENEMYPRO_y2,
    input  logic        restart,
    output logic        CRASH,
    output logic [3:0]  lives,
    output logic        game_over,
    output logic [15:0] hit_count
);

    localparam int MAXC = (HIT_CYCLES > INV_CYCLES) ? HIT_CYCLES : INV_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [12:0] HW13      = 13'(HIT_W);
    localparam logic [TW-1:0] HIT_END = TW'(HIT_CYCLES - 1);
    localparam logic [TW-1:0] INV_END = TW'(INV_CYCLES - 1);
    localparam logic [3:0]  LIVES_RST = 4'(LIVES_INIT);

    typedef enum logic [1:0] {PLAY, HIT, INVULN, OVER} state_t;

    state_t         state, state_n;
    logic           hit_q;
    logic [TW-1:0]  timer, timer_n;
    logic           crash_n;
    logic [3:0]     lives_n;
    logic           game_over_n;
    logic [15:0]    hit_count_n;
    logic           accept;
    logic [2:0]     ov;

    // One axis of the box test, widened by one bit so a box near 4095 cannot wrap onto 0
    function automatic logic axis_overlap(input logic [11:0] a, input logic [11:0] b);
        return (({1'b0, a} + HW13) > {1'b0, b}) && (({1'b0, b} + HW13) > {1'b0, a});
    endfunction

    // Per-projectile box overlap against the plane
    always_comb begin
        ov[0] = axis_overlap(PLANE_x, ENEMYPRO_x0) && axis_overlap(PLANE_y, ENEMYPRO_y0);
        ov[1] = axis_overlap(PLANE_x, ENEMYPRO_x1) && axis_overlap(PLANE_y, ENEMYPRO_y1);
        ov[2] = axis_overlap(PLANE_x, ENEMYPRO_x2) && axis_overlap(PLANE_y, ENEMYPRO_y2);
    end

    // Register the combined overlap; simultaneous overlaps collapse into one hit
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= |ov;
        end
    end

    // Next-state and next-output logic; INVULN's final cycle doubles as the first PLAY edge
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        crash_n     = CRASH;
        lives_n     = lives;
        game_over_n = game_over;
        hit_count_n = hit_count;
        accept      = 1'b0;

        case (state)
            PLAY: begin
                accept = hit_q;
            end
            HIT: begin
                if (timer == HIT_END) begin
                    state_n = INVULN;
                    crash_n = 1'b0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            INVULN: begin
                if (timer == INV_END) begin
                    state_n = PLAY;
                    timer_n = '0;
                    accept  = hit_q;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            OVER: begin
                if (restart) begin
                    state_n     = PLAY;
                    lives_n     = LIVES_RST;
                    crash_n     = 1'b0;
                    game_over_n = 1'b0;
                    timer_n     = '0;
                end
            end
            default: begin
                state_n = PLAY;
            end
        endcase

        if (accept) begin
            hit_count_n = (hit_count == 16'hFFFF) ? hit_count : hit_count + 16'd1;
            crash_n     = 1'b1;
            timer_n     = '0;
            if (lives > 4'd1) begin
                state_n = HIT;
                lives_n = lives - 4'd1;
            end else begin
                state_n     = OVER;
                lives_n     = 4'd0;
                game_over_n = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PLAY;
            timer     <= '0;
            CRASH     <= 1'b0;
            lives     <= LIVES_RST;
            game_over <= 1'b0;
            hit_count <= 16'd0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            CRASH     <= crash_n;
            lives     <= lives_n;
            game_over <= game_over_n;
            hit_count <= hit_count_n;
        end
    end

endmodule

// File: tb/tb_collision_ctrl.sv
// tb/tb_collision_ctrl.sv - self-checking bench for collision_ctrl with directed scenarios and random stimulus
module tb_collision_ctrl;

    localparam int HW  = 40;
    localparam int HC  = 4;
    localparam int IC  = 8;
    localparam int LI  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] px = 12'd600, py = 12'd350;
    logic [11:0] ex0 = 12'd1180, ey0 = 12'd350;
    logic [11:0] ex1 = 12'd100,  ey1 = 12'd20;
    logic [11:0] ex2 = 12'd30,   ey2 = 12'd700;
    logic        restart = 1'b0;
    logic        CRASH;
    logic [3:0]  lives;
    logic        game_over;
    logic [15:0] hit_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    // reference model state: countdowns rather than an explicit state machine
    int m_crash_left = 0;
    int m_inv_left   = 0;
    bit m_over       = 0;
    int m_lives      = LI;
    int m_hits       = 0;
    bit m_hq         = 0;

    collision_ctrl #(.HIT_W(HW), .HIT_CYCLES(HC), .INV_CYCLES(IC), .LIVES_INIT(LI)) dut (
        .clk(clk), .rst(rst),
        .PLANE_x(px), .PLANE_y(py),
        .ENEMYPRO_x0(ex0), .ENEMYPRO_y0(ey0),
        .ENEMYPRO_x1(ex1), .ENEMYPRO_y1(ey1),
        .ENEMYPRO_x2(ex2), .ENEMYPRO_y2(ey2),
        .restart(restart),
        .CRASH(CRASH), .lives(lives), .game_over(game_over), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit near(input int a, input int b);
        int d;
        d = (a > b) ? a - b : b - a;
        return d < HW;
    endfunction

    function automatic bit m_overlap(input int ex, input int ey);
        return near(int'(px), ex) && near(int'(py), ey);
    endfunction

    function automatic void m_accept();
        if (m_hits < 65535) m_hits++;
        if (m_lives > 1) begin
            m_lives--;
            m_crash_left = HC;
        end else begin
            m_lives = 0;
            m_over  = 1;
        end
    endfunction

    // model advances on every clock edge from the same inputs the DUT samples
    always @(posedge clk) begin
        bit ov;
        ov = m_overlap(int'(ex0), int'(ey0)) || m_overlap(int'(ex1), int'(ey1)) ||
             m_overlap(int'(ex2), int'(ey2));
        if (rst) begin
            m_crash_left = 0; m_inv_left = 0; m_over = 0;
            m_lives = LI; m_hits = 0; m_hq = 0;
        end else begin
            if (m_over) begin
                if (restart) begin
                    m_over = 0;
                    m_lives = LI;
                end
            end else if (m_crash_left > 0) begin
                m_crash_left--;
                if (m_crash_left == 0) m_inv_left = IC;
            end else if (m_inv_left > 0) begin
                m_inv_left--;
                if (m_inv_left == 0 && m_hq) m_accept();
            end else if (m_hq) begin
                m_accept();
            end
            m_hq = ov;
        end
    end

    // compare all outputs against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_crash", 32'(CRASH), 32'(m_over || m_crash_left > 0));
            check("m_lives", 32'(lives), 32'(m_lives));
            check("m_over", 32'(game_over), 32'(m_over));
            check("m_hits", 32'(hit_count), 32'(m_hits));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] clampc(input int v);
        if (v < 0) return 12'd0;
        if (v > 4095) return 12'd4095;
        return 12'(v);
    endfunction

    task automatic rand_positions();
        int base;
        if ($urandom_range(0, 9) == 0) begin
            px = 12'($urandom_range(4060, 4095));
            py = 12'($urandom_range(0, 4095));
        end else if ($urandom_range(0, 7) == 0) begin
            px = 12'($urandom_range(0, 4095));
            py = 12'($urandom_range(0, 4095));
        end
        base = int'(px);
        ex0 = clampc(base + int'($urandom_range(0, 140)) - 70);
        ex1 = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 30))
                                           : clampc(base + int'($urandom_range(0, 140)) - 70);
        ex2 = clampc(base + int'($urandom_range(0, 200)) - 100);
        base = int'(py);
        ey0 = clampc(base + int'($urandom_range(0, 140)) - 70);
        ey1 = clampc(base + int'($urandom_range(0, 140)) - 70);
        ey2 = clampc(base + int'($urandom_range(0, 200)) - 100);
    endtask

    task automatic clear_proj();
        ex0 = 12'd1180; ey0 = 12'd350;
        ex1 = 12'd100;  ey1 = 12'd20;
        ex2 = 12'd30;   ey2 = 12'd700;
    endtask

    initial begin
        tick(2);
        chk_en = 1;
        check("rst_lives", 32'(lives), 32'd3);
        check("rst_crash", 32'(CRASH), 32'd0);
        rst = 1'b0;
        tick(100);
        check("idle_hits", 32'(hit_count), 32'd0);

        // held hit: two accepted hits then game over
        ex0 = 12'd620; ey0 = 12'd360;
        tick(2);
        check("crash_t2", 32'(CRASH), 32'd1);
        tick(1);
        check("lives_t3", 32'(lives), 32'd2);
        check("hits_t3", 32'(hit_count), 32'd1);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(2);
        check("crash_t6", 32'(CRASH), 32'd0);
        tick(8);
        check("crash_t14", 32'(CRASH), 32'd1);
        check("lives_t14", 32'(lives), 32'd1);
        tick(20);
        check("over_go", 32'(game_over), 32'd1);
        check("over_lives", 32'(lives), 32'd0);
        check("over_crash", 32'(CRASH), 32'd1);
        check("over_hits", 32'(hit_count), 32'd3);
        clear_proj();
        tick(3);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        check("rs_go", 32'(game_over), 32'd0);
        check("rs_lives", 32'(lives), 32'd3);
        check("rs_crash", 32'(CRASH), 32'd0);
        check("rs_hits", 32'(hit_count), 32'd3);

        // exact edge and no-wrap cases
        tick(2);
        ex0 = 12'd640;
        tick(10);
        check("edge40", 32'(hit_count), 32'd3);
        ex0 = 12'd639;
        tick(4);
        check("edge39", 32'(hit_count), 32'd4);
        clear_proj();
        tick(15);
        px = 12'd4090; ex0 = 12'd10; ey0 = 12'd350;
        tick(10);
        check("nowrap", 32'(hit_count), 32'd4);
        px = 12'd600;
        clear_proj();
        tick(3);

        // three simultaneous overlaps count once
        ex0 = 12'd610; ey0 = 12'd340;
        ex1 = 12'd590; ey1 = 12'd360;
        ex2 = 12'd600; ey2 = 12'd350;
        tick(4);
        check("tri_hits", 32'(hit_count), 32'd5);
        check("tri_lives", 32'(lives), 32'd1);
        clear_proj();
        tick(15);

        // reset in the middle of HIT
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ex0 = 12'd620; ey0 = 12'd360;
        tick(4);
        rst = 1'b1;
        clear_proj();
        tick(1);
        rst = 1'b0;
        check("mrst_crash", 32'(CRASH), 32'd0);
        check("mrst_lives", 32'(lives), 32'd3);
        check("mrst_hits", 32'(hit_count), 32'd0);

        // randomized phase, checked against the model every cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) rand_positions();
            restart = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        restart = 1'b0;
        tick(2);
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
